// File: rtl/io_port_fifo_if.sv
// Handshake and bus bundle for the buffered in/out port block.
// The slave view belongs to the FIFO block; the master view belongs to its surroundings.
interface io_port_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ipo;
    logic [WIDTH-1:0] bus_out;
    logic             opi;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    in_count;
    logic [CW-1:0]    out_count;
    logic             in_unf;
    logic             out_ovf;
    logic             clr_err;

    modport master (
        output in_data, in_valid, ipo, opi, bus_in, out_ready, clr_err,
        input  in_ready, bus_out, out_data, out_valid, in_count, out_count, in_unf, out_ovf
    );

    modport slave (
        input  in_data, in_valid, ipo, opi, bus_in, out_ready, clr_err,
        output in_ready, bus_out, out_data, out_valid, in_count, out_count, in_unf, out_ovf
    );
endinterface

// File: rtl/io_port_fifo.sv
// Buffered port block: producer -> input FIFO -> bus (ipo), bus (opi) -> output FIFO -> consumer.
// Both FIFOs are circular buffers with combinational head reads and sticky error flags.
module io_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic           clock,
    input  logic           clear,
    io_port_fifo_if.slave  port
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // ---------------- input side ----------------
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [AW-1:0]    in_wr_ptr_reg;
    logic [AW-1:0]    in_rd_ptr_reg;
    logic [CW-1:0]    in_count_reg;
    logic [CW-1:0]    in_count_next;
    logic             in_unf_reg;
    logic             in_full;
    logic             in_empty;
    logic             in_push;
    logic             in_pop;
    logic             in_underflow;
    logic [DEPTH-1:0] in_we;

    assign in_full      = (in_count_reg == CW'(DEPTH));
    assign in_empty     = (in_count_reg == '0);
    assign in_push      = port.in_valid & ~in_full;
    assign in_pop       = port.ipo & ~in_empty;
    assign in_underflow = port.ipo & in_empty;

    always_comb begin
        in_count_next = in_count_reg;
        case ({in_push, in_pop})
            2'b10:   in_count_next = in_count_reg + CW'(1);
            2'b01:   in_count_next = in_count_reg - CW'(1);
            default: in_count_next = in_count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            in_wr_ptr_reg <= '0;
            in_rd_ptr_reg <= '0;
            in_count_reg  <= '0;
            in_unf_reg    <= 1'b0;
        end else begin
            if (in_push)
                in_wr_ptr_reg <= in_wr_ptr_reg + AW'(1);
            if (in_pop)
                in_rd_ptr_reg <= in_rd_ptr_reg + AW'(1);
            in_count_reg <= in_count_next;
            // A new underflow outranks a coincident clear request.
            if (in_underflow)
                in_unf_reg <= 1'b1;
            else if (port.clr_err)
                in_unf_reg <= 1'b0;
        end
    end

    // ---------------- output side ----------------
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [AW-1:0]    out_wr_ptr_reg;
    logic [AW-1:0]    out_rd_ptr_reg;
    logic [CW-1:0]    out_count_reg;
    logic [CW-1:0]    out_count_next;
    logic             out_ovf_reg;
    logic             out_full;
    logic             out_empty;
    logic             out_drain;
    logic             out_capture;
    logic             out_overflow;
    logic [DEPTH-1:0] out_we;

    assign out_full     = (out_count_reg == CW'(DEPTH));
    assign out_empty    = (out_count_reg == '0);
    assign out_drain    = ~out_empty & port.out_ready;
    // A drain on the same edge frees the slot, so a full FIFO can still capture.
    assign out_capture  = port.opi & (~out_full | out_drain);
    assign out_overflow = port.opi & ~out_capture;

    always_comb begin
        out_count_next = out_count_reg;
        case ({out_capture, out_drain})
            2'b10:   out_count_next = out_count_reg + CW'(1);
            2'b01:   out_count_next = out_count_reg - CW'(1);
            default: out_count_next = out_count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
            out_ovf_reg    <= 1'b0;
        end else begin
            if (out_capture)
                out_wr_ptr_reg <= out_wr_ptr_reg + AW'(1);
            if (out_drain)
                out_rd_ptr_reg <= out_rd_ptr_reg + AW'(1);
            out_count_reg <= out_count_next;
            if (out_overflow)
                out_ovf_reg <= 1'b1;
            else if (port.clr_err)
                out_ovf_reg <= 1'b0;
        end
    end

    // ---------------- storage ----------------
    // One-hot per-entry write enables; the arrays themselves carry no reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign in_we[gi]  = in_push     && (in_wr_ptr_reg  == AW'(gi));
            assign out_we[gi] = out_capture && (out_wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (in_we[i])
                in_mem[i] <= port.in_data;
            if (out_we[i])
                out_mem[i] <= port.bus_in;
        end
    end

    // ---------------- outputs ----------------
    assign port.in_ready  = ~in_full;
    assign port.bus_out   = in_pop ? in_mem[in_rd_ptr_reg] : '0;
    assign port.out_valid = ~out_empty;
    assign port.out_data  = out_empty ? '0 : out_mem[out_rd_ptr_reg];
    assign port.in_count  = in_count_reg;
    assign port.out_count = out_count_reg;
    assign port.in_unf    = in_unf_reg;
    assign port.out_ovf   = out_ovf_reg;
endmodule
